// File: rtl/datapath_pkg.sv
// Shared constants for the datapath core: opcodes, FSM state encoding
// and flag-bit positions.
package datapath_pkg;

    // Opcodes, numbered in issue order; unlisted codes execute as NOP.
    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_NOT  = 6;
    localparam int OP_SHL  = 7;
    localparam int OP_SHR  = 8;
    localparam int OP_MOVI = 9;
    localparam int OP_LD   = 10;
    localparam int OP_ST   = 11;
    localparam int OP_JMP  = 12;
    localparam int OP_BRZ  = 13;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Bit positions inside the packed flag register.
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: result plus carry/borrow, zero and sign indications.
// Non-ALU opcodes yield a zero result with carry clear.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4
) (
    input  logic [OP_SIZE-1:0]   op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 carry,
    output logic                 zero,
    output logic                 neg
);

    logic [WORD_SIZE:0] wide;

    // Operation select; SUB carry is the borrow out of the extended subtract.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (int'(op))
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[WORD_SIZE-1:0];
                carry  = wide[WORD_SIZE];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[WORD_SIZE-1:0];
                carry  = wide[WORD_SIZE];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[WORD_SIZE-2:0], 1'b0};
                carry  = a[WORD_SIZE-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WORD_SIZE-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WORD_SIZE-1];

endmodule

// File: rtl/datapath_core.sv
// Self-sequencing datapath: register file, registered ALU flags, program
// counter and a req/ack memory port. One micro-op per IDLE->EXEC->(MEM)->WB.
// Optional feature: define MEM_TIMEOUT_EN for a memory watchdog and sticky err.
//
// state | meaning
// IDLE  | op_ready high, waiting for op_valid
// EXEC  | ALU result / flags registered from the latched op
// MEM   | mem_req held for LD/ST until mem_ack (or watchdog expiry)
// WB    | register write, pc update, done pulse
module datapath_core
    import datapath_pkg::*;
#(
    parameter  int WORD_SIZE      = 8,
    parameter  int NUM_REGS       = 8,
    parameter  int OP_SIZE        = 4,
    parameter  int PC_WIDTH       = 8,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int RW             = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [OP_SIZE-1:0]   op_code,
    input  logic [RW-1:0]        rd,
    input  logic [RW-1:0]        rs1,
    input  logic [RW-1:0]        rs2,
    input  logic [WORD_SIZE-1:0] imm,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [PC_WIDTH-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 zflag,
    output logic                 cflag,
    output logic                 nflag,
    output logic                 done,
    output logic                 err
);

    logic [1:0]           state;
    logic [OP_SIZE-1:0]   op_q;
    logic [RW-1:0]        rd_q, rs1_q, rs2_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [WORD_SIZE-1:0] wb_data;
    logic                 wb_we;
    logic [NUM_FLAGS-1:0] flags;
    logic [PC_WIDTH-1:0]  pc_q;

    logic [WORD_SIZE-1:0] src_a, src_b, alu_result;
    logic                 alu_carry, alu_zero, alu_neg;
    logic                 is_alu, is_mem, is_ld, is_st, to_hit;
    int                   opc;

    assign src_a = regs[rs1_q];
    assign src_b = regs[rs2_q];

    datapath_alu #(
        .WORD_SIZE(WORD_SIZE),
        .OP_SIZE  (OP_SIZE)
    ) u_alu (
        .op    (op_q),
        .a     (src_a),
        .b     (src_b),
        .result(alu_result),
        .carry (alu_carry),
        .zero  (alu_zero),
        .neg   (alu_neg)
    );

    // Opcode class decode of the latched op.
    always_comb begin
        opc    = int'(op_q);
        is_alu = (opc >= OP_ADD) && (opc <= OP_SHR);
        is_ld  = (opc == OP_LD);
        is_st  = (opc == OP_ST);
        is_mem = is_ld || is_st;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign to_hit = (to_cnt == '0);
    assign err    = err_q;

    // Watchdog: down-counter armed in EXEC, terminal count in MEM sets err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == ST_EXEC) begin
            to_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (state == ST_MEM && !mem_ack) begin
            if (to_hit) err_q  <= 1'b1;
            else        to_cnt <= to_cnt - TW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Sequencer, op register, register file, flags and pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            wb_data <= '0;
            wb_we   <= 1'b0;
            flags   <= '0;
            pc_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q  <= op_code;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        imm_q <= imm;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wb_we   <= is_alu || (opc == OP_MOVI);
                    wb_data <= (opc == OP_MOVI) ? imm_q : alu_result;
                    if (is_alu) begin
                        flags[FLAG_Z] <= alu_zero;
                        flags[FLAG_C] <= alu_carry;
                        flags[FLAG_N] <= alu_neg;
                    end
                    state <= is_mem ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (is_ld) begin
                            wb_data <= mem_rdata;
                            wb_we   <= 1'b1;
                        end
                        state <= ST_WB;
                    end else if (to_hit) begin
                        state <= ST_WB;
                    end
                end
                default: begin
                    if (wb_we) regs[rd_q] <= wb_data;
                    if (opc == OP_JMP || (opc == OP_BRZ && flags[FLAG_Z]))
                        pc_q <= imm_q[PC_WIDTH-1:0];
                    else
                        pc_q <= pc_q + PC_WIDTH'(1);
                    wb_we <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (state == ST_IDLE);
    assign mem_req   = (state == ST_MEM);
    assign mem_we    = mem_req && is_st;
    assign mem_addr  = src_a[PC_WIDTH-1:0];
    assign mem_wdata = src_b;
    assign done      = (state == ST_WB);
    assign pc        = pc_q;
    assign zflag     = flags[FLAG_Z];
    assign cflag     = flags[FLAG_C];
    assign nflag     = flags[FLAG_N];

endmodule
